omp_pixel_uart_tx: RTL and testbench
====================================

OMP_PIXEL_UART_TX -- requirements
Module: omp_pixel_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (115200 baud at 100 MHz); legal range 2..4095.
REQ-002 SHALL have parameter HDR_BYTE, default 8'hA5, frame header byte.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pixel_addr  input  6  recovered-image pixel index 0..63.
REQ-006 SHALL have port pixel_val  input  24  pixel value.
REQ-007 SHALL have port pixel_we  input  1  write strobe for pixel_addr/pixel_val.
REQ-008 SHALL have port frame_done  input  1  one-cycle pulse marking the last pixel of the image (system done pulse).
REQ-009 SHALL have port uart_txd  output  1  UART 8N1 serial line, idle high.
REQ-010 SHALL have port busy  output  1  high while a frame is being transmitted.
REQ-011 SHALL have port frame_sent  output  1  one-cycle pulse at end of frame.
REQ-012 SHALL have port overrun  output  1  sticky flag: a write or frame_done was dropped.

Function
REQ-013 SHALL hold a 64 x 24-bit pixel buffer; pixel_we writes pixel_val at pixel_addr on the clock edge, only when busy=0.
REQ-014 SHALL ignore pixel_we while busy=1, set overrun, and leave the buffer unchanged.
REQ-015 SHALL use FSM states IDLE, START, DATA, STOP, DONE.
- IDLE: frame_done=1 -> START; busy rises on the same edge.
- START: uart_txd=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles -> STOP.
- STOP: uart_txd=1 for CLKS_PER_BIT cycles -> START if more bytes remain, else DONE.
- DONE: one cycle with frame_sent=1 and busy=0 -> IDLE.
REQ-016 SHALL transmit exactly 194 bytes per frame, in this order:
- HDR_BYTE;
- for pixel 0..63: bits 23:16, then 15:8, then 7:0;
- checksum = XOR of the 192 pixel bytes (header excluded).
REQ-017 SHALL sequence bytes with an 8-bit byte counter 0..193; the pixel index is counter-1 divided by 3, and the byte lane is the remainder.
REQ-018 SHALL place each stop bit immediately before the next start bit, with no idle gap between bytes.
REQ-019 SHALL make the start bit of the header begin on the first cycle after frame_done is sampled.
REQ-020 SHALL make the whole frame occupy exactly 194*10*CLKS_PER_BIT cycles, followed by the DONE cycle.
REQ-021 SHALL accumulate the checksum as each pixel byte is loaded; the accumulator clears when leaving IDLE.
REQ-022 SHALL commit a simultaneous pixel_we and frame_done in IDLE to the buffer before the frame is captured; that pixel is included in the frame.
REQ-023 SHALL ignore frame_done while busy=1 (no queuing) and set overrun.
REQ-024 SHALL clear overrun only by reset.
REQ-025 SHALL hold uart_txd high in IDLE and DONE.

Reset
REQ-026 SHALL, when rst_n=0, immediately (asynchronously) drive:
- state IDLE;
- uart_txd=1, busy=0, frame_sent=0, overrun=0;
- byte counter, bit counter, baud counter and checksum to 0;
- all buffer entries to 24'h000000.
REQ-027 SHALL, on reset asserted mid-frame, abort the frame: uart_txd=1 immediately, no frame_sent pulse, and the next frame starts from the header.
REQ-028 SHALL leave IDLE only on a frame_done sampled after rst_n deasserts.

Verification (CLKS_PER_BIT=4)
REQ-029 SHALL cover a basic frame:
- stimulus: write pixel k = {k, ~k, 8'h5A} for k=0..63, then pulse frame_done;
- response: 194 bytes decoded, first 8'hA5, then 00 FF 5A 01 FE 5A ...;
- checksum equals the XOR of all 192 pixel bytes;
- frame_sent pulses exactly 7760 cycles after the first start bit.
REQ-030 SHALL cover the frame_done/pixel_we collision:
- stimulus: pixel_we addr 63 = 24'h123456 in the same cycle as frame_done;
- response: last three pixel bytes are 12 34 56.
REQ-031 SHALL cover writes while busy:
- stimulus: pixel_we addr 0 = 24'hFFFFFF during the frame;
- response: overrun=1, current frame unaffected;
- a second frame still sends the old pixel-0 value.
REQ-032 SHALL cover a repeated frame_done while busy:
- stimulus: second frame_done pulse mid-frame;
- response: overrun=1, exactly one frame_sent, busy low after DONE.
REQ-033 SHALL cover reset mid-frame:
- stimulus: rst_n low during the DATA bits of byte 50;
- response: uart_txd=1 in the same cycle, busy=0, overrun=0;
- the next frame_done yields a frame of all-zero pixels with checksum 8'h00.
REQ-034 SHALL check serial timing on every frame:
- start bit low for 4 cycles, stop bit high for 4 cycles;
- no high gap longer than 4 cycles between bytes.

Source files
------------

// File: rtl/omp_pixel_uart_tx.sv
// Buffers a 64-pixel, 24-bit image and streams it over a UART 8N1 line as one frame:
// a header byte, 192 pixel bytes (MSB lane first) and an XOR checksum.
module omp_pixel_uart_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  pixel_addr,
  input  logic [23:0] pixel_val,
  input  logic        pixel_we,
  input  logic        frame_done,
  output logic        uart_txd,
  output logic        busy,
  output logic        frame_sent,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  localparam logic [11:0] BAUD_LAST = 12'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  LAST_BYTE = 8'd193;

  state_t      state, next_state;
  logic [23:0] pix_buf [64];
  logic [7:0]  byte_cnt;
  logic [7:0]  cur_byte;
  logic [7:0]  checksum;
  logic [2:0]  bit_cnt;
  logic [11:0] baud_cnt;
  logic        bit_done;

  logic [5:0]  pix_idx;
  logic [1:0]  lane;
  logic [23:0] pix_word;
  logic [7:0]  next_byte;
  logic        next_is_pixel;

  assign bit_done = (baud_cnt == BAUD_LAST);

  // The byte about to be loaded is number byte_cnt+1, so its pixel offset is byte_cnt itself.
  always_comb begin
    pix_idx       = 6'(byte_cnt / 8'd3);
    lane          = 2'(byte_cnt % 8'd3);
    pix_word      = pix_buf[pix_idx];
    next_is_pixel = (byte_cnt < 8'd192);
    case (lane)
      2'd0:    next_byte = pix_word[23:16];
      2'd1:    next_byte = pix_word[15:8];
      default: next_byte = pix_word[7:0];
    endcase
    if (!next_is_pixel) next_byte = checksum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (frame_done) next_state = START;
      START: if (bit_done) next_state = DATA;
      DATA:  if (bit_done && bit_cnt == 3'd7) next_state = STOP;
      STOP:  if (bit_done) next_state = (byte_cnt == LAST_BYTE) ? DONE : START;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    uart_txd   = 1'b1;
    busy       = 1'b0;
    frame_sent = 1'b0;
    case (state)
      START: begin uart_txd = 1'b0;              busy = 1'b1; end
      DATA:  begin uart_txd = cur_byte[bit_cnt]; busy = 1'b1; end
      STOP:  busy = 1'b1;
      DONE:  frame_sent = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      checksum <= '0;
      cur_byte <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_done) begin
            byte_cnt <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            checksum <= '0;
            cur_byte <= HDR_BYTE;
          end
        end
        START, DATA, STOP: begin
          baud_cnt <= bit_done ? 12'd0 : baud_cnt + 12'd1;
          if (state == DATA && bit_done) bit_cnt <= bit_cnt + 3'd1;
          // Next byte is loaded at the end of the stop bit so its start bit follows without a gap.
          if (state == STOP && bit_done && byte_cnt != LAST_BYTE) begin
            byte_cnt <= byte_cnt + 8'd1;
            cur_byte <= next_byte;
            if (next_is_pixel) checksum <= checksum ^ next_byte;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) pix_buf[i] <= '0;
    end else if (pixel_we && !busy) begin
      pix_buf[pixel_addr] <= pixel_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun <= 1'b0;
    else if ((pixel_we && busy) || (frame_done && state != IDLE)) overrun <= 1'b1;
  end

endmodule

// File: tb/tb_omp_pixel_uart_tx.sv
// Self-checking bench for omp_pixel_uart_tx: frames are decoded off the serial line
// and compared with bytes derived from a reference copy of the pixel buffer.
module tb_omp_pixel_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  pixel_addr = '0;
  logic [23:0] pixel_val = '0;
  logic        pixel_we = 1'b0;
  logic        frame_done = 1'b0;
  logic        uart_txd, busy, frame_sent, overrun;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] model_buf [64];
  logic [7:0]  exp_bytes [194];
  logic [7:0]  got_bytes [194];

  omp_pixel_uart_tx #(.CLKS_PER_BIT(4), .HDR_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n),
    .pixel_addr(pixel_addr), .pixel_val(pixel_val), .pixel_we(pixel_we),
    .frame_done(frame_done),
    .uart_txd(uart_txd), .busy(busy), .frame_sent(frame_sent), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] addr, input logic [23:0] val);
    pixel_addr = addr;
    pixel_val  = val;
    pixel_we   = 1'b1;
    @(negedge clk);
    pixel_we   = 1'b0;
    model_buf[addr] = val;
  endtask

  // Expected frame: header, every pixel split MSB lane first, then XOR of the pixel bytes.
  function automatic void buildExpected();
    logic [7:0] cs = 8'h00;
    exp_bytes[0] = 8'hA5;
    for (int p = 0; p < 64; p++) begin
      for (int l = 0; l < 3; l++) begin
        exp_bytes[1 + 3*p + l] = 8'(model_buf[p] >> (16 - 8*l));
        cs ^= exp_bytes[1 + 3*p + l];
      end
    end
    exp_bytes[193] = cs;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 64; i++) model_buf[i] = '0;
  endtask

  task automatic startFrame();
    buildExpected();
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  // Called on the first negedge after frame_done was sampled: that cycle is start-bit cycle 0.
  task automatic recvFrame(input string tag);
    int glitches = 0;
    int framing = 0;
    int status_err = 0;
    logic [7:0] b;
    logic s0;
    for (int n = 0; n < 194; n++) begin
      b = '0;
      for (int slot = 0; slot < 10; slot++) begin
        s0 = uart_txd;
        for (int c = 0; c < 4; c++) begin
          if (uart_txd !== s0) glitches++;
          if (frame_sent !== 1'b0 || busy !== 1'b1) status_err++;
          @(negedge clk);
        end
        if (slot == 0 && s0 !== 1'b0) framing++;
        if (slot == 9 && s0 !== 1'b1) framing++;
        if (slot >= 1 && slot <= 8) b[slot-1] = s0;
      end
      got_bytes[n] = b;
      checkOutput($sformatf("%s byte%0d", tag, n), {24'h0, b}, {24'h0, exp_bytes[n]});
    end
    checkOutput({tag, " bit_glitches"}, glitches, 0);
    checkOutput({tag, " start_stop"}, framing, 0);
    checkOutput({tag, " busy_during_frame"}, status_err, 0);
    checkOutput({tag, " frame_sent_at_7760"}, {31'h0, frame_sent}, 1);
    checkOutput({tag, " busy_in_done"}, {31'h0, busy}, 0);
    checkOutput({tag, " txd_in_done"}, {31'h0, uart_txd}, 1);
    @(negedge clk);
    checkOutput({tag, " frame_sent_single"}, {31'h0, frame_sent}, 0);
    checkOutput({tag, " txd_idle"}, {31'h0, uart_txd}, 1);
  endtask

  initial begin
    int quiet_err;
    clearModel();
    repeat (3) @(negedge clk);
    checkOutput("reset txd", {31'h0, uart_txd}, 1);
    checkOutput("reset busy", {31'h0, busy}, 0);
    checkOutput("reset frame_sent", {31'h0, frame_sent}, 0);
    checkOutput("reset overrun", {31'h0, overrun}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle txd", {31'h0, uart_txd}, 1);

    $display("[TB] basic frame");
    for (int k = 0; k < 64; k++) applyStimulus(6'(k), {8'(k), ~8'(k), 8'h5A});
    startFrame();
    recvFrame("basic");
    checkOutput("basic hdr", {24'h0, got_bytes[0]}, 32'hA5);
    checkOutput("basic p0_hi", {24'h0, got_bytes[1]}, 32'h00);
    checkOutput("basic p0_mid", {24'h0, got_bytes[2]}, 32'hFF);
    checkOutput("basic p0_lo", {24'h0, got_bytes[3]}, 32'h5A);
    checkOutput("basic p1_hi", {24'h0, got_bytes[4]}, 32'h01);
    checkOutput("basic p1_mid", {24'h0, got_bytes[5]}, 32'hFE);
    checkOutput("basic overrun", {31'h0, overrun}, 0);

    $display("[TB] random writes plus collision");
    for (int i = 0; i < 40; i++) applyStimulus(6'($urandom_range(0, 62)), 24'($urandom));
    pixel_addr = 6'd63;
    pixel_val  = 24'h123456;
    pixel_we   = 1'b1;
    model_buf[63] = 24'h123456;
    startFrame();
    pixel_we   = 1'b0;
    recvFrame("collision");
    checkOutput("collision p63_hi", {24'h0, got_bytes[190]}, 32'h12);
    checkOutput("collision p63_mid", {24'h0, got_bytes[191]}, 32'h34);
    checkOutput("collision p63_lo", {24'h0, got_bytes[192]}, 32'h56);
    checkOutput("collision overrun", {31'h0, overrun}, 0);

    $display("[TB] write while busy");
    startFrame();
    fork
      recvFrame("busywr");
      begin
        repeat (300) @(negedge clk);
        pixel_addr = 6'd0;
        pixel_val  = 24'hFFFFFF;
        pixel_we   = 1'b1;
        @(negedge clk);
        pixel_we   = 1'b0;
      end
    join
    checkOutput("busywr overrun", {31'h0, overrun}, 1);
    startFrame();
    recvFrame("oldpix");
    checkOutput("oldpix overrun_sticky", {31'h0, overrun}, 1);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 10; i++) applyStimulus(6'($urandom_range(0, 63)), 24'($urandom) | 24'h1);
    startFrame();
    repeat (2010) @(negedge clk);
    checkOutput("pre_reset busy", {31'h0, busy}, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset txd", {31'h0, uart_txd}, 1);
    checkOutput("midreset busy", {31'h0, busy}, 0);
    checkOutput("midreset overrun", {31'h0, overrun}, 0);
    checkOutput("midreset frame_sent", {31'h0, frame_sent}, 0);
    clearModel();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("postreset busy", {31'h0, busy}, 0);
    checkOutput("postreset txd", {31'h0, uart_txd}, 1);
    startFrame();
    recvFrame("zero");
    checkOutput("zero checksum", {24'h0, got_bytes[193]}, 32'h00);
    checkOutput("zero overrun", {31'h0, overrun}, 0);

    $display("[TB] repeated frame_done while busy");
    for (int i = 0; i < 20; i++) applyStimulus(6'($urandom_range(0, 63)), 24'($urandom));
    startFrame();
    fork
      recvFrame("repeat");
      begin
        repeat (3000) @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
      end
    join
    checkOutput("repeat overrun", {31'h0, overrun}, 1);
    quiet_err = 0;
    for (int i = 0; i < 40; i++) begin
      if (frame_sent !== 1'b0 || busy !== 1'b0 || uart_txd !== 1'b1) quiet_err++;
      @(negedge clk);
    end
    checkOutput("repeat quiet_after", quiet_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
